// File: rtl/fifo_rx_packet_parser.sv
// Read-side consumer of the FWFT receive FIFO: frames header/length/payload packets
// and packs the payload little-endian into 16-bit words with a valid/ready output.
module fifo_rx_packet_parser #(
    parameter int MaxErrCount = 255
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [8:0]  FifoDout,
    input  logic        FifoValid,
    output logic        FifoRead,
    output logic        HdrValid,
    output logic [7:0]  HdrCmd,
    output logic [7:0]  HdrLen,
    output logic [15:0] OutData,
    output logic        OutValid,
    input  logic        OutReady,
    output logic        OutLast,
    output logic        PktAbort,
    output logic [7:0]  ErrCount
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LEN  = 2'd1;
    localparam logic [1:0] ST_LO   = 2'd2;
    localparam logic [1:0] ST_HI   = 2'd3;
    localparam logic [7:0] ERR_MAX = 8'(MaxErrCount);

    logic [1:0]  state_r;
    logic [7:0]  remain_r;
    logic [7:0]  low_r;
    logic [7:0]  hdr_cmd_r;
    logic [7:0]  hdr_len_r;
    logic [7:0]  err_count_r;
    logic        hdr_valid_r;
    logic        pkt_abort_r;
    logic        out_valid_r;
    logic        out_last_r;
    logic [15:0] out_data_r;

    logic        marker_s;
    logic [7:0]  byte_s;
    logic        out_free_s;
    logic        can_take_s;
    logic        pop_s;
    logic        word_done_s;
    logic        word_last_s;
    logic [15:0] word_data_s;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v >= ERR_MAX) ? ERR_MAX : v + 8'd1;
    endfunction

    assign marker_s   = FifoDout[8];
    assign byte_s     = FifoDout[7:0];
    assign out_free_s = !out_valid_r || OutReady;

    // Stall only on data bytes that would complete a word while the output is full
    always_comb begin
        can_take_s = 1'b1;
        case (state_r)
            ST_IDLE, ST_LEN: can_take_s = 1'b1;
            ST_LO: begin
                if (!marker_s && remain_r == 8'd1) can_take_s = out_free_s;
                else                               can_take_s = 1'b1;
            end
            ST_HI: begin
                if (!marker_s) can_take_s = out_free_s;
                else           can_take_s = 1'b1;
            end
            default: can_take_s = 1'b1;
        endcase
    end

    assign pop_s    = FifoValid && !Reset && can_take_s;
    assign FifoRead = pop_s;

    // Word assembly from the popped data byte
    always_comb begin
        word_done_s = 1'b0;
        word_last_s = 1'b0;
        word_data_s = 16'h0000;
        if (pop_s && !marker_s && state_r == ST_LO && remain_r == 8'd1) begin
            word_done_s = 1'b1;
            word_last_s = 1'b1;
            word_data_s = {8'h00, byte_s};
        end else if (pop_s && !marker_s && state_r == ST_HI) begin
            word_done_s = 1'b1;
            word_last_s = (remain_r == 8'd1);
            word_data_s = {byte_s, low_r};
        end else begin
            word_done_s = 1'b0;
        end
    end

    // Packet framing state machine, header fields and error counter
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r     <= ST_IDLE;
            remain_r    <= 8'd0;
            low_r       <= 8'd0;
            hdr_cmd_r   <= 8'd0;
            hdr_len_r   <= 8'd0;
            err_count_r <= 8'd0;
            hdr_valid_r <= 1'b0;
            pkt_abort_r <= 1'b0;
        end else begin
            hdr_valid_r <= 1'b0;
            pkt_abort_r <= 1'b0;
            if (pop_s && marker_s) begin
                // A marker always starts a new packet; mid-packet it aborts the old one
                hdr_cmd_r <= byte_s;
                low_r     <= 8'd0;
                state_r   <= ST_LEN;
                if (state_r != ST_IDLE) begin
                    pkt_abort_r <= 1'b1;
                    err_count_r <= sat_inc(err_count_r);
                end
            end else if (pop_s) begin
                case (state_r)
                    ST_IDLE: err_count_r <= sat_inc(err_count_r);
                    ST_LEN: begin
                        hdr_len_r   <= byte_s;
                        remain_r    <= byte_s;
                        hdr_valid_r <= 1'b1;
                        state_r     <= (byte_s == 8'd0) ? ST_IDLE : ST_LO;
                    end
                    ST_LO: begin
                        remain_r <= remain_r - 8'd1;
                        low_r    <= byte_s;
                        state_r  <= (remain_r == 8'd1) ? ST_IDLE : ST_HI;
                    end
                    ST_HI: begin
                        remain_r <= remain_r - 8'd1;
                        state_r  <= (remain_r == 8'd1) ? ST_IDLE : ST_LO;
                    end
                    default: state_r <= ST_IDLE;
                endcase
            end else begin
                state_r <= state_r;
            end
        end
    end

    // Single-stage output register; a completing word reloads even while being accepted
    always_ff @(posedge Clk) begin
        if (Reset) begin
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            out_data_r  <= 16'h0000;
        end else if (word_done_s) begin
            out_valid_r <= 1'b1;
            out_last_r  <= word_last_s;
            out_data_r  <= word_data_s;
        end else if (OutReady) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign HdrValid = hdr_valid_r;
    assign HdrCmd   = hdr_cmd_r;
    assign HdrLen   = hdr_len_r;
    assign OutData  = out_data_r;
    assign OutValid = out_valid_r;
    assign OutLast  = out_last_r;
    assign PktAbort = pkt_abort_r;
    assign ErrCount = err_count_r;
endmodule
